// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default widths and
// bit-timing helpers used by both the receiver and the transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int HALF_BIT         = CLKS_PER_BIT_DEF / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  function automatic int half_of(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, strobing at mid-bit
// and at the last cycle of the bit; clr restarts it from zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_CNT     = HALF_BIT
) (
  input  logic clk,
  input  logic prst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  logic [TW-1:0] cnt;

  assign full_tick = (cnt == TW'(CLKS_PER_BIT - 1));
  assign half_tick = (cnt == TW'(HALF_CNT - 1));

  // free-running bit counter, wraps at the end of each bit period
  always_ff @(posedge clk) begin
    if (!prst || clr) begin
      cnt <= '0;
    end else if (full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART 8N1 receiver with valid/ready output and error pulses.
// Optional even parity: define UART_RX_PARITY_EN.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  prst,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  uart_state_e state, state_n;

  logic                  rx_q1;
  logic                  rx_s;
  logic                  half_tick;
  logic                  full_tick;
  logic                  timer_clr;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  smp_data;
  logic                  smp_stop;
  logic                  par_bad;
  logic                  good;
  logic                  accept;
  logic                  load;

  // two-flop synchroniser; line idles high
  always_ff @(posedge clk) begin
    if (!prst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= serial_in;
      rx_s  <= rx_q1;
    end
  end

  assign timer_clr = (state_n != state);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_CNT     (half_of(CLKS_PER_BIT))
  ) u_timer (
    .clk       (clk),
    .prst      (prst),
    .clr       (timer_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!prst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic smp_par;
  logic par_bit;
`endif

  // next-state and sample strobes
  always_comb begin
    state_n  = state;
    smp_data = 1'b0;
    smp_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    smp_par  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        if (half_tick) begin
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_tick) begin
          smp_data = 1'b1;
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (full_tick) begin
          smp_par = 1'b1;
          state_n = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (full_tick) begin
          smp_stop = 1'b1;
          state_n  = rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // data-bit counter and LSB-first shift register
  always_ff @(posedge clk) begin
    if (!prst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (timer_clr) begin
        bit_cnt <= '0;
      end else if (smp_data) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (smp_data) begin
        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // captured parity bit
  always_ff @(posedge clk) begin
    if (!prst) begin
      par_bit <= 1'b0;
    end else if (smp_par) begin
      par_bit <= rx_s;
    end
  end

  assign par_bad = ^{shreg, par_bit};

  // parity error pulse; a bad stop bit wins
  always_ff @(posedge clk) begin
    if (!prst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= smp_stop && rx_s && par_bad;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign good   = smp_stop && rx_s && !par_bad;
  assign accept = data_valid && data_ready;
  assign load   = good && (!data_valid || accept);

  // output register, handshake and error pulses
  always_ff @(posedge clk) begin
    if (!prst) begin
      parallel_out <= '0;
      data_valid   <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      frame_err   <= smp_stop && !rx_s;
      overrun_err <= good && data_valid && !data_ready;
      if (load) begin
        parallel_out <= shreg;
        data_valid   <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
